// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - core request / CSR file signal bundle for trap_sequencer
interface trap_sequencer_if;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        ext_irq;
    logic        mie;
    logic        mret_valid;
    logic        csr_valid;
    logic [1:0]  csr_type;
    logic [11:0] csr_num;
    logic [31:0] csr_wdata;
    logic        csr_nowrite;
    logic [31:0] pc;
    logic [31:0] csr_rdata;
    logic        csr_invalid;

    logic [11:0] csr_addr;
    logic [31:0] csr_bus;
    logic [31:0] addr;
    logic        csr_read;
    logic        csr_write;
    logic [1:0]  csr_write_type;
    logic        trap;
    logic [4:0]  trap_cause;
    logic        take_external_interupt;
    logic        ret;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  exc_valid, exc_cause, exc_addr, ext_irq, mie, mret_valid,
               csr_valid, csr_type, csr_num, csr_wdata, csr_nowrite, pc,
               csr_rdata, csr_invalid,
        output csr_addr, csr_bus, addr, csr_read, csr_write, csr_write_type,
               trap, trap_cause, take_external_interupt, ret, busy, done,
               rdata, redirect_valid, redirect_pc
    );

    modport master (
        output exc_valid, exc_cause, exc_addr, ext_irq, mie, mret_valid,
               csr_valid, csr_type, csr_num, csr_wdata, csr_nowrite, pc,
               csr_rdata, csr_invalid,
        input  csr_addr, csr_bus, addr, csr_read, csr_write, csr_write_type,
               trap, trap_cause, take_external_interupt, ret, busy, done,
               rdata, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode CSR/trap/MRET sequencer owning all CSR file controls
// Optional external interrupt path enabled by defining TRAP_SEQ_IRQ_EN.
module trap_sequencer #(
    parameter logic [11:0] MTVEC_ADDR    = 12'h305,
    parameter logic [11:0] MEPC_ADDR     = 12'h341,
    parameter logic [4:0]  ILLEGAL_CAUSE = 5'd2,
    parameter logic [4:0]  EXT_IRQ_CAUSE = 5'd11
) (
    input logic              clk,
    input logic              rst,
    trap_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CSR_RD, S_CSR_WR, S_TRAP, S_VEC, S_EPC, S_RET
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [11:0] num_q, num_d;
    logic [31:0] wdata_q, wdata_d;
    logic        nowrite_q, nowrite_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] fault_q, fault_d;
    logic [31:0] pc_q, pc_d;
    logic        irq_q, irq_d;
    logic [31:0] old_q, old_d;
    logic        irq_req;

`ifdef TRAP_SEQ_IRQ_EN
    assign irq_req = bus.ext_irq & bus.mie;
`else
    assign irq_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            num_q     <= '0;
            wdata_q   <= '0;
            nowrite_q <= 1'b0;
            cause_q   <= '0;
            fault_q   <= '0;
            pc_q      <= '0;
            irq_q     <= 1'b0;
            old_q     <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            num_q     <= num_d;
            wdata_q   <= wdata_d;
            nowrite_q <= nowrite_d;
            cause_q   <= cause_d;
            fault_q   <= fault_d;
            pc_q      <= pc_d;
            irq_q     <= irq_d;
            old_q     <= old_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        num_d     = num_q;
        wdata_d   = wdata_q;
        nowrite_d = nowrite_q;
        cause_d   = cause_q;
        fault_d   = fault_q;
        pc_d      = pc_q;
        irq_d     = irq_q;
        old_d     = old_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.exc_valid) begin
                    cause_d = bus.exc_cause;
                    fault_d = bus.exc_addr;
                    pc_d    = bus.pc;
                    irq_d   = 1'b0;
                    state_d = S_TRAP;
                end else if (irq_req) begin
                    cause_d = EXT_IRQ_CAUSE;
                    fault_d = '0;
                    pc_d    = bus.pc;
                    irq_d   = 1'b1;
                    state_d = S_TRAP;
                end else if (bus.mret_valid) begin
                    pc_d    = bus.pc;
                    state_d = S_EPC;
                end else if (bus.csr_valid) begin
                    type_d    = bus.csr_type;
                    num_d     = bus.csr_num;
                    wdata_d   = bus.csr_wdata;
                    nowrite_d = bus.csr_nowrite;
                    pc_d      = bus.pc;
                    state_d   = S_CSR_RD;
                end
            end
            S_CSR_RD: begin
                old_d = bus.csr_rdata;
                if (bus.csr_invalid) begin
                    // Illegal access reuses the exception path; mepc is the CSR instruction's pc.
                    cause_d = ILLEGAL_CAUSE;
                    fault_d = '0;
                    irq_d   = 1'b0;
                    state_d = S_TRAP;
                end else if (nowrite_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CSR_WR;
                end
            end
            S_CSR_WR: state_d = S_IDLE;
            S_TRAP:   state_d = S_VEC;
            S_VEC:    state_d = S_IDLE;
            S_EPC: begin
                old_d   = bus.csr_rdata;
                state_d = S_RET;
            end
            S_RET:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.csr_addr               = '0;
        bus.csr_bus                = '0;
        bus.addr                   = '0;
        bus.csr_read               = 1'b0;
        bus.csr_write              = 1'b0;
        bus.csr_write_type         = 2'b00;
        bus.trap                   = 1'b0;
        bus.trap_cause             = '0;
        bus.take_external_interupt = 1'b0;
        bus.ret                    = 1'b0;
        bus.busy                   = (state_q != S_IDLE);
        bus.done                   = 1'b0;
        bus.rdata                  = '0;
        bus.redirect_valid         = 1'b0;
        bus.redirect_pc            = '0;
        unique case (state_q)
            S_CSR_RD: begin
                bus.csr_read = 1'b1;
                bus.csr_addr = num_q;
                if (!bus.csr_invalid && nowrite_q) begin
                    bus.done  = 1'b1;
                    bus.rdata = bus.csr_rdata;
                end
            end
            S_CSR_WR: begin
                bus.csr_write      = 1'b1;
                bus.csr_write_type = type_q;
                bus.csr_bus        = wdata_q;
                bus.done           = 1'b1;
                bus.rdata          = old_q;
            end
            S_TRAP: begin
                bus.trap       = 1'b1;
                bus.trap_cause = cause_q;
                bus.csr_bus    = pc_q;
                bus.addr       = fault_q;
`ifdef TRAP_SEQ_IRQ_EN
                bus.take_external_interupt = irq_q;
`else
                bus.take_external_interupt = 1'b0;
`endif
            end
            S_VEC: begin
                bus.csr_read       = 1'b1;
                bus.csr_addr       = MTVEC_ADDR;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = bus.csr_rdata;
            end
            S_EPC: begin
                bus.csr_read = 1'b1;
                bus.csr_addr = MEPC_ADDR;
            end
            S_RET: begin
                bus.ret            = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = old_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer with a transaction-level model
module tb_trap_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_sequencer_if bus();
    trap_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  wtype;
        logic [11:0] caddr;
        logic [31:0] cbus;
        logic [31:0] addr;
        logic        trap;
        logic [4:0]  cause;
        logic        irq;
        logic        ret;
        logic        done;
        logic [31:0] rdata;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    typedef struct packed {
        logic        exc;
        logic        irq;
        logic        mie;
        logic        mret;
        logic        csr;
        logic [4:0]  cause;
        logic [31:0] eaddr;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [1:0]  ctype;
        logic [11:0] num;
        logic        nowrite;
    } req_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    logic [31:0] mepc_val = 32'h80;
    logic [11:0] num_tab [6] = '{12'h340, 12'hF14, 12'h7C0, 12'h300, 12'h341, 12'h305};

    // Tiny CSR file: fixed contents, 0x7C0 is the one unimplemented address.
    function automatic logic [31:0] csr_val(input logic [11:0] a);
        case (a)
            12'h305: return 32'h4;
            12'h341: return mepc_val;
            12'h340: return 32'h0;
            12'hF14: return 32'h0;
            12'h300: return 32'h1808;
            default: return 32'hA5A5_0000 | {20'h0, a};
        endcase
    endfunction

    always_comb begin
        bus.csr_rdata   = csr_val(bus.csr_addr);
        bus.csr_invalid = bus.csr_read && (bus.csr_addr == 12'h7C0);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t trap_rec(input logic [4:0] c, input logic [31:0] p, input logic [31:0] a, input logic i);
        exp_t e = '0;
        e.trap = 1'b1; e.cause = c; e.cbus = p; e.addr = a; e.irq = i;
        return e;
    endfunction

    function automatic exp_t vec_rec();
        exp_t e = '0;
        e.rd = 1'b1; e.caddr = 12'h305; e.rv = 1'b1; e.rpc = 32'h4;
        return e;
    endfunction

    // Expected per-cycle behaviour of one accepted request, derived from the request kind.
    task automatic model_push(input req_t r, input int limit, output int n);
        exp_t l[$];
        exp_t e;
        bit irq_win;
`ifdef TRAP_SEQ_IRQ_EN
        irq_win = r.irq && r.mie;
`else
        irq_win = 1'b0;
`endif
        if (r.exc) begin
            l.push_back(trap_rec(r.cause, r.pc, r.eaddr, 1'b0));
            l.push_back(vec_rec());
        end else if (irq_win) begin
            l.push_back(trap_rec(5'd11, r.pc, 32'h0, 1'b1));
            l.push_back(vec_rec());
        end else if (r.mret) begin
            e = '0; e.rd = 1'b1; e.caddr = 12'h341; l.push_back(e);
            e = '0; e.ret = 1'b1; e.rv = 1'b1; e.rpc = mepc_val; l.push_back(e);
        end else if (r.csr) begin
            e = '0; e.rd = 1'b1; e.caddr = r.num;
            if (r.num == 12'h7C0) begin
                l.push_back(e);
                l.push_back(trap_rec(5'd2, r.pc, 32'h0, 1'b0));
                l.push_back(vec_rec());
            end else if (r.nowrite) begin
                e.done = 1'b1; e.rdata = csr_val(r.num);
                l.push_back(e);
            end else begin
                l.push_back(e);
                e = '0; e.wr = 1'b1; e.wtype = r.ctype; e.cbus = r.wdata;
                e.done = 1'b1; e.rdata = csr_val(r.num);
                l.push_back(e);
            end
        end
        n = 0;
        foreach (l[i]) if (i < limit) begin sb.push_back(l[i]); n++; end
    endtask

    task automatic apply(input req_t r);
        bus.exc_valid = r.exc; bus.exc_cause = r.cause; bus.exc_addr = r.eaddr;
        bus.ext_irq = r.irq; bus.mie = r.mie; bus.mret_valid = r.mret;
        bus.csr_valid = r.csr; bus.csr_type = r.ctype; bus.csr_num = r.num;
        bus.csr_wdata = r.wdata; bus.csr_nowrite = r.nowrite; bus.pc = r.pc;
    endtask

    task automatic clear_req();
        req_t z = '0;
        apply(z);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the request is dropped.
    task automatic run_req(input req_t r);
        int n;
        bit seen = 1'b0;
        apply(r);
        model_push(r, 100, n);
        if (n == 0) begin
            repeat (3) @(posedge clk);
            #1 clear_req();
            return;
        end
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (bus.done || bus.redirect_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk("completion_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(posedge clk);
        #1 clear_req();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("csr_read", {31'd0, bus.csr_read}, {31'd0, e.rd});
                    chk("csr_write", {31'd0, bus.csr_write}, {31'd0, e.wr});
                    chk("csr_write_type", {30'd0, bus.csr_write_type}, {30'd0, e.wtype});
                    chk("csr_addr", {20'd0, bus.csr_addr}, {20'd0, e.caddr});
                    chk("csr_bus", bus.csr_bus, e.cbus);
                    chk("addr", bus.addr, e.addr);
                    chk("trap", {31'd0, bus.trap}, {31'd0, e.trap});
                    chk("trap_cause", {27'd0, bus.trap_cause}, {27'd0, e.cause});
                    chk("take_irq", {31'd0, bus.take_external_interupt}, {31'd0, e.irq});
                    chk("ret", {31'd0, bus.ret}, {31'd0, e.ret});
                    chk("done", {31'd0, bus.done}, {31'd0, e.done});
                    chk("rdata", bus.rdata, e.rdata);
                    chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rv});
                    chk("redirect_pc", bus.redirect_pc, e.rpc);
                end
            end else begin
                chk("idle_strobes", {24'd0, bus.csr_read, bus.csr_write, bus.csr_write_type,
                    bus.trap, bus.take_external_interupt, bus.ret, bus.done}, 32'd0);
                chk("idle_redirect", {31'd0, bus.redirect_valid}, 32'd0);
                chk("idle_csr_addr", {20'd0, bus.csr_addr}, 32'd0);
                chk("idle_bus_addr", bus.csr_bus | bus.addr, 32'd0);
                chk("idle_data", bus.rdata | bus.redirect_pc | {27'd0, bus.trap_cause}, 32'd0);
            end
        end
    end

    initial begin
        req_t r;
        int n;
        clear_req();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        r = '0; r.csr = 1; r.ctype = 2'b01; r.num = 12'h340; r.wdata = 32'hDEADBEEF; r.pc = 32'h40;
        run_req(r);
        r = '0; r.csr = 1; r.ctype = 2'b10; r.num = 12'hF14; r.nowrite = 1; r.pc = 32'h44;
        run_req(r);
        r = '0; r.csr = 1; r.ctype = 2'b01; r.num = 12'h7C0; r.wdata = 32'h1; r.pc = 32'h100;
        run_req(r);
        r = '0; r.exc = 1; r.cause = 5'd4; r.eaddr = 32'h2003; r.pc = 32'h80;
        r.mret = 1; r.csr = 1; r.ctype = 2'b11; r.num = 12'h340;
        run_req(r);
        r = '0; r.mret = 1; r.pc = 32'h300;
        run_req(r);
        r = '0; r.irq = 1; r.mie = 1; r.pc = 32'h200;
        run_req(r);

        // Reset while in CSR_RD: only the first cycle of the sequence may appear.
        r = '0; r.csr = 1; r.ctype = 2'b01; r.num = 12'h340; r.wdata = 32'h55; r.pc = 32'h60;
        apply(r);
        model_push(r, 1, n);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_req();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_abandon_queue", sb.size(), 32'd0);
        r = '0; r.csr = 1; r.ctype = 2'b10; r.num = 12'h300; r.wdata = 32'h8; r.pc = 32'h64;
        run_req(r);

        for (int t = 0; t < 200; t++) begin
            mepc_val = $urandom & 32'hFFFF_FFFC;
            r = '0;
            r.exc = ($urandom_range(0, 4) == 0);
            r.irq = $urandom_range(0, 1);
            r.mie = $urandom_range(0, 1);
            r.mret = ($urandom_range(0, 3) == 0);
            r.csr = $urandom_range(0, 1);
            r.cause = 5'($urandom_range(0, 15));
            r.eaddr = $urandom;
            r.pc = $urandom & 32'hFFFF_FFFC;
            r.wdata = $urandom;
            r.ctype = 2'($urandom_range(1, 3));
            r.num = num_tab[$urandom_range(0, 5)];
            r.nowrite = $urandom_range(0, 1);
            run_req(r);
        end

        @(posedge clk); #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
